// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmit and receive paths.
//   Holds the TX FSM state encoding, the default system clock / baud rate,
//   and the bit-period calculation (clock cycles per bit).
//   Optional macro UART_TX_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

  localparam int DEF_CLK_FREQ = 65_000_000;
  localparam int DEF_UART_BPS = 115_200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with occupancy output.
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset (clears pointers and level)
//   i_wr_en   : write request, ignored while full
//   i_wr_data : byte to write
//   i_rd_en   : read request, ignored while empty
//   o_rd_data : byte at the head of the FIFO (valid while not empty)
//   o_level   : number of stored bytes, 0..DEPTH
//   o_full    : level == DEPTH
//   o_empty   : level == 0
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  // full/empty come from the level, so a wrapped pointer pair is never ambiguous
  assign o_full    = r_level == LW'(DEPTH);
  assign o_empty   = r_level == '0;
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter (8 data bits, LSB first, 1 stop bit).
//   sys_clk    : clock, rising edge
//   sys_rst_n  : asynchronous active-low reset; aborts any frame, drops the buffer
//   tx_valid   : tx_data offered; accepted when tx_ready is high
//   tx_data    : byte to send
//   tx_ready   : buffer not full
//   uart_txd   : registered serial output, idle high
//   tx_busy    : frame on the line or bytes still buffered
//   fifo_level : buffered byte count
//   Macro UART_TX_PARITY_EN inserts an even-parity bit after D7 (11-bit frame).
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int UART_BPS   = DEF_UART_BPS,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_data,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int BW = BPS_CNT > 1 ? $clog2(BPS_CNT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BPS_CNT - 1);

  tx_state_e  r_state;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       r_txd;
`ifdef UART_TX_PARITY_EN
  logic       r_par;
`endif
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_bit_end;
  logic [7:0] w_fifo_data;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (sys_clk),
    .i_rst_n   (sys_rst_n),
    .i_wr_en   (tx_valid),
    .i_wr_data (tx_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_level   (fifo_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_bit_end = r_baud == BAUD_LAST;
  // load a new byte when idle, or back-to-back at the end of the stop bit
  assign w_pop     = !w_empty && (r_state == IDLE || (r_state == STOP && w_bit_end));
  assign tx_ready  = !w_full;
  assign tx_busy   = r_state != IDLE || !w_empty;
  assign uart_txd  = r_txd;

  // the line value for each state is registered on entry, so uart_txd
  // changes on the same edge as the state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_baud <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + BW'(1);
      if (w_pop) begin
        r_state <= START;
        r_shift <= w_fifo_data;
        r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^w_fifo_data;
`endif
      end else if (w_bit_end) begin
        case (r_state)
          START: begin
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end
          DATA: begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_par;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_txd <= r_shift[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
`endif
          STOP: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: randomized self-checking bench against a frame-timeline model.
module tb_uart_tx_buf;

  localparam int CLK_FREQ = 1_600_000;
  localparam int UART_BPS = 100_000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
  localparam int DEPTH    = 16;
  localparam int DBPS     = 564;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * BPS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, txd, busy;
  logic [4:0] level;
  logic       d_valid = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_ready, d_txd, d_busy;
  logic [4:0] d_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  int         t = -1;
  logic [7:0] cur = 8'h00;

  always #5 clk = ~clk;

  uart_tx_buf #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .tx_valid(valid),
    .tx_data(data),
    .tx_ready(ready),
    .uart_txd(txd),
    .tx_busy(busy),
    .fifo_level(level)
  );

  uart_tx_buf dut_def (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .tx_valid(d_valid),
    .tx_data(d_data),
    .tx_ready(d_ready),
    .uart_txd(d_txd),
    .tx_busy(d_busy),
    .fifo_level(d_level)
  );

  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NB - 1) return 1'b1;
    return ^b;
  endfunction

  function automatic logic [7:0] exp_vec();
    return {(t < 0) ? 1'b1 : fbit(cur, t / BPS), (t >= 0 || q.size() > 0),
            (q.size() < DEPTH), 5'(q.size())};
  endfunction

  task automatic cyc();
    int   lvl;
    logic pop;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      t = -1;
    end else begin
      lvl = q.size();
      pop = lvl > 0 && (t < 0 || t == FR - 1);
      if (pop) begin
        cur = q.pop_front();
        t = 0;
      end else if (t == FR - 1) t = -1;
      else if (t >= 0) t++;
      if (valid && lvl < DEPTH) q.push_back(data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({txd, busy, ready, level} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset_async: txd/busy/ready/level got %b want %b", {txd, busy, ready, level}, 8'b1010_0000);
    end
    checks++;
    if ({d_txd, d_busy, d_ready, d_level} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset_default_inst: got %b want %b", {d_txd, d_busy, d_ready, d_level}, 8'b1010_0000);
    end
    repeat (3) cyc();
    checks++;
    if ({txd, busy, ready, level} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", {txd, busy, ready, level}, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default_a5();
    d_valid = 1'b1;
    d_data = 8'hA5;
    cyc();
    d_valid = 1'b0;
    checks++;
    if (d_txd !== 1'b1 || d_level !== 5'd1) begin
      errors++;
      $display("FAIL a5_first_cycle: txd=%b level=%0d want txd=1 level=1", d_txd, d_level);
    end
    cyc();
    for (int k = 0; k < NB * DBPS; k++) begin
      checks++;
      if (d_txd !== fbit(8'hA5, k / DBPS) || d_busy !== 1'b1) begin
        errors++;
        $display("FAIL a5_frame k=%0d: txd=%b busy=%b want txd=%b busy=1", k, d_txd, d_busy, fbit(8'hA5, k / DBPS));
      end
      cyc();
    end
    checks++;
    if (d_busy !== 1'b0 || d_txd !== 1'b1) begin
      errors++;
      $display("FAIL a5_end: busy=%b txd=%b want busy=0 txd=1", d_busy, d_txd);
    end
  endtask

  task automatic test_single();
    valid = 1'b1;
    data = 8'($urandom);
    cyc();
    valid = 1'b0;
    for (int n = 0; n < FR + 8; n++) begin
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL single n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) begin
      valid = 1'b1;
      data = 8'(i);
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_push i=%0d: got %b want %b", i, {txd, busy, ready, level}, exp_vec());
      end
    end
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL b2b_full: ready=%b level=%0d want ready=0 level=16", ready, level);
    end
    for (int n = 0; n < 17 * FR + 8; n++) begin
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_line n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
    end
  endtask

  task automatic test_full_hold();
    for (int i = 0; i < 17; i++) begin
      valid = 1'b1;
      data = 8'($urandom_range(0, 254));
      cyc();
    end
    data = 8'hFF;
    for (int n = 0; n < FR + 4 && q.size() == DEPTH; n++) begin
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL full_hold n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
      cyc();
    end
    valid = 1'b0;
    checks++;
    if (level !== 5'd15 || ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: level=%0d ready=%b want level=15 ready=1", level, ready);
    end
    for (int n = 0; n < 16 * FR + 8; n++) begin
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
    end
  endtask

  task automatic test_push_pop3();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data = 8'($urandom);
      cyc();
    end
    valid = 1'b0;
    for (int n = 0; n < FR + 4 && t != FR - 1; n++) begin
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL pp3_wait n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
      cyc();
    end
    valid = 1'b1;
    data = 8'($urandom);
    cyc();
    valid = 1'b0;
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL pp3_level: level=%0d want 3", level);
    end
    for (int n = 0; n < 4 * FR + 8; n++) begin
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL pp3_drain n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data = (i == 0) ? (8'($urandom) & 8'hF7) : 8'($urandom);
      cyc();
    end
    valid = 1'b0;
    for (int n = 0; n < 2 * FR && t < 4 * BPS + BPS / 2; n++) begin
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_mid_pre n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
      cyc();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({txd, busy, ready, level} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL rst_mid_async: got %b want %b", {txd, busy, ready, level}, 8'b1010_0000);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int n = 0; n < 3 * FR; n++) begin
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_mid_after n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
    end
  endtask

  task automatic test_frame_len();
    int   k = 0;
    logic pbit = 1'b0;
    valid = 1'b1;
    data = 8'h07;
    cyc();
    valid = 1'b0;
    cyc();
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL len_start: txd=%b want 0", txd);
    end
    while (busy && k < 2 * FR) begin
      if (k == 9 * BPS + BPS / 2) pbit = txd;
      cyc();
      k++;
    end
    checks++;
    if (k !== FR) begin
      errors++;
      $display("FAIL len_frame: busy cycles=%0d want %0d", k, FR);
    end
    checks++;
    if (pbit !== 1'b1) begin
      errors++;
      $display("FAIL len_bit9: txd=%b want 1", pbit);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      valid = $urandom_range(0, 3) == 0;
      data = 8'($urandom);
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL random n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
    end
    valid = 1'b0;
    for (int n = 0; n < 17 * FR + 8; n++) begin
      cyc();
      checks++;
      if ({txd, busy, ready, level} !== exp_vec()) begin
        errors++;
        $display("FAIL random_drain n=%0d: got %b want %b", n, {txd, busy, ready, level}, exp_vec());
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_default_a5();
    test_single();
    test_back_to_back();
    test_full_hold();
    test_push_pop3();
    test_reset_midframe();
    test_frame_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLK_FREQ, default 65_000_000, SHALL set the system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, SHALL set the line baud rate.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two >= 2, SHALL set the transmit buffer depth in bytes.
REQ-004 sys_clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 tx_valid  input  1  SHALL mark tx_data as offered for buffering.
REQ-007 tx_data  input  8  SHALL carry the byte to transmit.
REQ-008 tx_ready  output  1  SHALL be high when the buffer can accept a byte (not full).
REQ-009 uart_txd  output  1  SHALL be the registered serial line output, idle high.
REQ-010 tx_busy  output  1  SHALL be high while a frame is on the line or the buffer is non-empty.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  SHALL give the current buffered byte count.

Function
REQ-012 Bit period SHALL be BPS_CNT = CLK_FREQ/UART_BPS cycles (integer division; 564 at defaults).
REQ-013 A byte SHALL be written when tx_valid && tx_ready; tx_ready SHALL depend only on the registered level, never on a same-cycle pop.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 In IDLE with fifo_level != 0, the FSM SHALL pop one byte into the shift register and enter START next cycle.
REQ-016 Latency: byte accepted into an empty idle buffer at cycle N SHALL drive uart_txd low from cycle N+2.
REQ-017 START SHALL drive 0; DATA SHALL drive D0..D7 LSB first; STOP SHALL drive 1; each bit held exactly BPS_CNT cycles.
REQ-018 In the last STOP cycle with fifo_level != 0, the FSM SHALL pop and go directly to START (no idle gap); otherwise it SHALL go to IDLE.
REQ-019 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve byte order.
REQ-020 Push when full SHALL be ignored without corrupting stored data; pop SHALL never occur when empty.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from fifo_level.
REQ-022 tx_busy SHALL be (state != IDLE) || (fifo_level != 0), registered or combinational from registers only.

Reset
REQ-023 On sys_rst_n low, asynchronously: uart_txd=1, tx_ready=1, tx_busy=0, fifo_level=0, state=IDLE, pointers and bit/baud counters=0.
REQ-024 Reset mid-frame SHALL abort the frame, return uart_txd high immediately and discard all buffered bytes.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, an even-parity bit SHALL follow D7 for one bit period (11-bit frame).
REQ-026 Without UART_TX_PARITY_EN, PARITY state and logic SHALL be absent (10-bit frame, 8N1).

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state encoding, default CLK_FREQ/UART_BPS, and the BPS_CNT calculation shared with the receive path.
REQ-028 Buffering SHALL be a sub-module uart_tx_fifo (synchronous FIFO, level output); serializer FSM remains in uart_tx_buf.

Verification
REQ-029 Push 0xA5 at cycle N, defaults -> txd low at N+2 for 564 cycles, then 1,0,1,0,0,1,0,1, stop high; tx_busy low 5640 cycles after N+2.
REQ-030 Push 17 bytes 0x00..0x10 on consecutive cycles -> all accepted (first popped early), tx_ready low while level=16, 17 contiguous frames in order, no idle gap between stop and start.
REQ-031 Hold tx_valid with 0xFF while full -> no acceptance, fifo_level stays 16, transmitted sequence unchanged.
REQ-032 Assert sys_rst_n low during D3 of a frame with 5 bytes buffered -> txd high same cycle, fifo_level 0, no further frames after release.
REQ-033 Push during the cycle a pop occurs at level 3 -> fifo_level stays 3, order preserved.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 11*564 cycles; without macro -> 10*564 cycles.
